uart_tx: RTL and testbench

Serial transmitter feeding the system's asynchronous serial line; the far end of that line is the UART receiver.
- Accepts a parallel word through a valid pulse.
- Frames the word as start bit, LSB-first data, optional parity and stop bit, and shifts it out on TX_OUT at one bit per CLK cycle.
- CLK is the baud-rate clock produced by the TX clock divider.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_serializer.sv | 43 ++++
 rtl/uart_tx.sv | 112 +++++++++++
 tb/tb_uart_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity selection constants
// and the default payload width. The receiver uses the same parity constants.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for the UART transmitter.
// Ports:
//   CLK, RST   - baud clock, async active-high reset
//   load       - capture load_data and clear the bit counter
//   shift      - rotate word right by one and advance the bit counter
//   load_data  - parallel word to capture
//   word       - current register contents; word[0] is the bit on the line
//   done_c     - counter sits on the last data bit
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  done_c
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [CNT_W-1:0] bit_cnt;

    // Rotate rather than shift so the full word stays intact for parity.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            word    <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            word    <= load_data;
            bit_cnt <= '0;
        end else if (shift) begin
            word    <= {word[0], word[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign done_c = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: frames a parallel word as start, LSB-first data,
// optional parity and stop bit, one bit per CLK cycle.
// Ports:
//   CLK, RST    - baud clock, async active-high reset
//   P_DATA      - word to send, sampled with Data_Valid in IDLE
//   Data_Valid  - send request (ignored while busy)
//   PAR_EN      - append parity bit
//   PAR_TYP     - PAR_EVEN / PAR_ODD
//   TX_OUT      - serial line, idle high, registered
//   busy        - frame in flight, registered
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    uart_state_e           state_q;
    uart_state_e           state_d;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  load;
    logic                  shift;
    logic                  tx_d;
    logic                  busy_d;
    logic                  par_bit;
    logic [DATA_WIDTH-1:0] word;
    logic                  done;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load),
        .shift     (shift),
        .load_data (P_DATA),
        .word      (word),
        .done_c    (done)
    );

    // XOR over the word is invariant under the serializer's rotation.
    assign par_bit = (par_typ_q == PAR_ODD) ? ~(^word) : (^word);

    // State register, output flops and request latch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
        end else begin
            state_q <= state_d;
            TX_OUT  <= tx_d;
            busy    <= busy_d;
            if (load) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
        end
    end

    // Next state and next output values; outputs are decoded from the next
    // state so the flops present each bit in the cycle that state is active.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        tx_d    = 1'b1;
        busy_d  = 1'b1;

        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    state_d = START;
                    load    = 1'b1;
                end
            end
            START:  state_d = DATA;
            DATA: begin
                if (done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    shift = 1'b1;
                end
            end
            PARITY: state_d = STOP;
            STOP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            IDLE:   busy_d = 1'b0;
            START:  tx_d   = 1'b0;
            // Entering DATA the first bit is word[0]; while in DATA the
            // register still holds the bit on the line, so look one ahead.
            DATA:   tx_d   = (state_q == START) ? word[0] : word[1];
            PARITY: tx_d   = par_bit;
            default: tx_d  = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int unsigned DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          TX_OUT;
    logic          busy;

    int vectors    = 0;
    int miscompares = 0;

    // Expected {TX_OUT, busy} per cycle, pushed when a request is driven.
    logic [1:0] exp_q[$];

    uart_tx #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // Reference frame: start, LSB-first data, optional parity, stop, one idle.
    task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
        exp_q.push_back(2'b01);
        for (int i = 0; i < int'(DW); i++) exp_q.push_back({d[i], 1'b1});
        if (pe) exp_q.push_back({(^d) ^ pt, 1'b1});
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b10);
    endtask

    // Called at a negedge in IDLE: present a one-cycle request.
    task automatic request(input logic [DW-1:0] d, input logic pe, input logic pt);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        push_frame(d, pe, pt);
    endtask

    task automatic test_reset();
        RST = 1'b1; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        #1;
        vectors++;
        if ({TX_OUT, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_state got tx=%b busy=%b want tx=1 busy=0", TX_OUT, busy);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({TX_OUT, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL post_reset_idle got tx=%b busy=%b want tx=1 busy=0", TX_OUT, busy);
        end
    endtask

    // A5 without parity, also checked against the literal line pattern.
    task automatic test_no_parity();
        logic [1:0] exp;
        logic [9:0] seen;
        int         busy_cnt;
        int         k;
        seen = '0; busy_cnt = 0; k = 0;
        request(8'hA5, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            @(negedge CLK);
            Data_Valid = 1'b0;
            exp = exp_q.pop_front();
            if (k < 10) seen[k] = TX_OUT;
            if (busy === 1'b1) busy_cnt++;
            k++;
            vectors++;
            if ({TX_OUT, busy} !== exp) begin
                miscompares++;
                $display("FAIL no_parity_A5 cycle %0d got tx=%b busy=%b want tx=%b busy=%b",
                         k, TX_OUT, busy, exp[1], exp[0]);
            end
        end
        vectors++;
        if (seen !== 10'b1101001010) begin
            miscompares++;
            $display("FAIL A5_line_pattern got %b want %b (bit0 first, right to left)", seen, 10'b1101001010);
        end
        vectors++;
        if (busy_cnt != 10) begin
            miscompares++;
            $display("FAIL A5_busy_length got %0d want 10", busy_cnt);
        end
    endtask

    // All words in all three parity modes.
    task automatic test_parity();
        logic [1:0]    exp;
        logic [DW-1:0] words [3];
        int            k;
        words[0] = 8'hA5; words[1] = 8'hB5; words[2] = 8'hB1;
        for (int w = 0; w < 3; w++) begin
            for (int m = 0; m < 3; m++) begin
                request(words[w], m != 0, m == 2);
                k = 0;
                while (exp_q.size() != 0) begin
                    @(negedge CLK);
                    Data_Valid = 1'b0;
                    exp = exp_q.pop_front();
                    k++;
                    vectors++;
                    if ({TX_OUT, busy} !== exp) begin
                        miscompares++;
                        $display("FAIL parity word=%h mode=%0d cycle %0d got tx=%b busy=%b want tx=%b busy=%b",
                                 words[w], m, k, TX_OUT, busy, exp[1], exp[0]);
                    end
                end
            end
        end
    endtask

    // Inputs (and requests) churn during the frame; the latched word must win.
    task automatic test_input_hold();
        logic [1:0] exp;
        int         k;
        request(8'hB1, 1'b0, 1'b0);
        k = 0;
        while (exp_q.size() != 0) begin
            @(negedge CLK);
            exp = exp_q.pop_front();
            k++;
            vectors++;
            if ({TX_OUT, busy} !== exp) begin
                miscompares++;
                $display("FAIL input_hold_B1 cycle %0d got tx=%b busy=%b want tx=%b busy=%b",
                         k, TX_OUT, busy, exp[1], exp[0]);
            end
            P_DATA     = ~P_DATA;
            PAR_EN     = ~PAR_EN;
            PAR_TYP    = ~PAR_TYP;
            Data_Valid = (k < 9) ? k[0] : 1'b0;
        end
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
    endtask

    // Data_Valid held for 30 edges: three frames, one idle cycle between.
    task automatic test_back_to_back();
        logic [1:0] exp;
        int         k;
        request(8'h3C, 1'b0, 1'b0);
        push_frame(8'h3C, 1'b0, 1'b0);
        push_frame(8'h3C, 1'b0, 1'b0);
        k = 0;
        while (exp_q.size() != 0) begin
            @(negedge CLK);
            k++;
            if (k == 30) Data_Valid = 1'b0;
            exp = exp_q.pop_front();
            vectors++;
            if ({TX_OUT, busy} !== exp) begin
                miscompares++;
                $display("FAIL back_to_back cycle %0d got tx=%b busy=%b want tx=%b busy=%b",
                         k, TX_OUT, busy, exp[1], exp[0]);
            end
        end
        repeat (2) begin
            @(negedge CLK);
            vectors++;
            if ({TX_OUT, busy} !== 2'b10) begin
                miscompares++;
                $display("FAIL back_to_back_no_extra got tx=%b busy=%b want tx=1 busy=0", TX_OUT, busy);
            end
        end
    endtask

    // Reset mid-frame aborts at once; the next request yields a clean frame.
    task automatic test_reset_mid_frame();
        logic [1:0] exp;
        request(8'h5A, 1'b1, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            Data_Valid = 1'b0;
            exp = exp_q.pop_front();
            vectors++;
            if ({TX_OUT, busy} !== exp) begin
                miscompares++;
                $display("FAIL pre_abort cycle %0d got tx=%b busy=%b want tx=%b busy=%b",
                         k, TX_OUT, busy, exp[1], exp[0]);
            end
        end
        RST = 1'b1;
        #1;
        vectors++;
        if ({TX_OUT, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL abort_immediate got tx=%b busy=%b want tx=1 busy=0", TX_OUT, busy);
        end
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({TX_OUT, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL abort_idle got tx=%b busy=%b want tx=1 busy=0", TX_OUT, busy);
        end
        request(8'hB5, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            @(negedge CLK);
            Data_Valid = 1'b0;
            exp = exp_q.pop_front();
            vectors++;
            if ({TX_OUT, busy} !== exp) begin
                miscompares++;
                $display("FAIL after_abort got tx=%b busy=%b want tx=%b busy=%b",
                         TX_OUT, busy, exp[1], exp[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_input_hold();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
